// File: rtl/fpcvt_normalizer.sv
// rtl/fpcvt_normalizer.sv - two's-complement to sign/exp/sig/fifth normaliser ahead of the rounder
// Optional FPCVT_NORM_2BIT_EN: double-step shifts while two leading zeros and exponent budget remain.
module fpcvt_normalizer #(
    parameter int unsigned MAX_EXP = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [2:0]  out_exp,
    output logic [3:0]  out_sig,
    output logic        out_fifth_bit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic [11:0] m_q;
    logic [2:0]  exp_q;
    logic        out_valid_q;
    logic        out_sign_q;
    logic [2:0]  out_exp_q;
    logic [3:0]  out_sig_q;
    logic        out_fifth_q;

    logic [11:0] mag_d;
    logic [11:0] m_d;
    logic [2:0]  exp_d;
    logic        norm_exit;

    // The most negative sample has no positive twin in 12 bits, so it saturates.
    always_comb begin
        mag_d = in_data;
        if (in_data[11]) begin
            mag_d = (in_data == 12'h800) ? 12'h7FF : (~in_data + 12'd1);
        end
    end

    always_comb begin
        norm_exit = m_q[10] || (exp_q == 3'd0);
        m_d       = m_q << 1;
        exp_d     = exp_q - 3'd1;
`ifdef FPCVT_NORM_2BIT_EN
        if ((m_q[10:9] == 2'b00) && (exp_q >= 3'd2)) begin
            m_d   = m_q << 2;
            exp_d = exp_q - 3'd2;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            m_q         <= '0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
            out_fifth_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_data[11];
                        m_q     <= mag_d;
                        exp_q   <= 3'(MAX_EXP);
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (norm_exit) begin
                        out_sign_q  <= sign_q;
                        out_exp_q   <= exp_q;
                        out_sig_q   <= m_q[10:7];
                        out_fifth_q <= m_q[6];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        m_q   <= m_d;
                        exp_q <= exp_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign out_sign      = out_sign_q;
    assign out_exp       = out_exp_q;
    assign out_sig       = out_sig_q;
    assign out_fifth_bit = out_fifth_q;

endmodule

// File: tb/tb_fpcvt_normalizer.sv
// tb/tb_fpcvt_normalizer.sv - directed-vector bench with an arithmetic reference model
module tb_fpcvt_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [2:0]  out_exp;
    logic [3:0]  out_sig;
    logic        out_fifth_bit;

    fpcvt_normalizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_sig      (out_sig),
        .out_fifth_bit(out_fifth_bit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected result of the sample in flight
    logic       exp_active = 1'b0;
    logic [8:0] exp_word = '0;
    int         exp_lat = 0;
    logic       lat_seen = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: magnitude, leading-one position, shift count capped by the exponent range.
    task automatic model(input logic [11:0] d, output logic [8:0] word, output int lat);
        int v, mag, p, s, m;
        v = d[11] ? int'(d) - 4096 : int'(d);
        mag = (v < 0) ? -v : v;
        if (mag > 2047) mag = 2047;
        if (mag == 0) s = 7;
        else begin
            p = 0;
            for (int i = 0; i < 11; i++) if ((mag >> i) & 1) p = i;
            s = 10 - p;
            if (s > 7) s = 7;
        end
        m = mag << s;
        word = {d[11], 3'(7 - s), 4'((m >> 7) & 15), 1'((m >> 6) & 1)};
`ifdef FPCVT_NORM_2BIT_EN
        lat = 1 + (s + 1) / 2;
`else
        lat = 1 + s;
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_active) begin
                chk("stale_out_valid", 1, 0);
            end else begin
                chk("model_word", int'({out_sign, out_exp, out_sig, out_fifth_bit}), int'(exp_word));
                chk("in_ready_busy", int'(in_ready), 0);
                if (!lat_seen) begin
                    chk("model_latency", cyc - acc_cyc, exp_lat);
                    lat_seen = 1'b1;
                end
            end
        end
    end

    // use_lit: also pin against hand-computed word/latency. hold: cycles out_ready stays low in DONE.
    task automatic send(input logic [11:0] d, input logic use_lit, input logic [8:0] lit_word,
                        input int lit_lat1, input int lit_lat2, input int hold, input logic early);
        logic [8:0] w;
        int l;
        int k;
        logic got;
        model(d, w, l);
        for (k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("in_ready_before_send", int'(in_ready), 1);
        exp_word   = w;
        exp_lat    = l;
        lat_seen   = 1'b0;
        exp_active = 1'b1;
        in_valid   = 1'b1;
        in_data    = d;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = ~d;
        if (early) out_ready = 1'b1;
        got = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("out_valid_timeout", 0, 1);
            exp_active = 1'b0;
            out_ready  = 1'b0;
            return;
        end
        if (use_lit) begin
            chk("lit_word", int'({out_sign, out_exp, out_sig, out_fifth_bit}), int'(lit_word));
`ifdef FPCVT_NORM_2BIT_EN
            chk("lit_latency", cyc - acc_cyc, lit_lat2);
`else
            chk("lit_latency", cyc - acc_cyc, lit_lat1);
`endif
        end
        if (!early) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_after_take", int'(out_valid), 0);
        chk("in_ready_after_take", int'(in_ready), 1);
        out_ready  = 1'b0;
        exp_active = 1'b0;
    endtask

    initial begin
        logic [8:0] w;
        int l;
        logic [11:0] r;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_word", int'({out_sign, out_exp, out_sig, out_fifth_bit}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        send(12'h7FF, 1'b1, 9'b0_111_1111_1, 1, 1, 0, 1'b0);
        send(12'h800, 1'b1, 9'b1_111_1111_1, 1, 1, 0, 1'b0);
        send(12'hFF0, 1'b1, 9'b1_001_1000_0, 7, 4, 0, 1'b0);
        send(12'h0B4, 1'b1, 9'b0_100_1011_0, 4, 3, 3, 1'b0);
        send(12'h000, 1'b1, 9'b0_000_0000_0, 8, 5, 0, 1'b0);
        send(12'h001, 1'b1, 9'b0_000_0001_0, 8, 5, 0, 1'b1);
        send(12'hFFF, 1'b1, 9'b1_000_0001_0, 8, 5, 2, 1'b0);
        send(12'h400, 1'b1, 9'b0_111_1000_0, 1, 1, 0, 1'b1);
        send(12'h3FF, 1'b1, 9'b0_110_1111_1, 2, 2, 1, 1'b0);
        send(12'h0C0, 1'b1, 9'b0_100_1100_0, 4, 3, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            r = 12'($urandom);
            send(r, 1'b0, 9'h0, 0, 0, i % 3, (i % 4) == 1);
        end

        // reset while the 0x010 sample is still normalising
        model(12'h010, w, l);
        exp_word   = w;
        exp_lat    = l;
        lat_seen   = 1'b0;
        exp_active = 1'b1;
        in_valid   = 1'b1;
        in_data    = 12'h010;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_active = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_word", int'({out_sign, out_exp, out_sig, out_fifth_bit}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        repeat (12) @(negedge clk);
        chk("midrst_no_stale", int'(out_valid), 0);

        send(12'h010, 1'b1, 9'b0_001_1000_0, 7, 4, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
